if_id_queue: RTL and testbench

- Small instruction queue between the fetch stage and the decode stage.
- Captures the instruction word and incremented PC (PC+2) produced by fetch, and presents them to decode in order.
- Backpressures fetch through `f_ready`, which drives fetch's `pcwren`.
- Supports flush on taken branch/jump and halt latching.

---
 rtl/if_id_queue_pkg.sv | 19 +
 rtl/if_id_entry_ram.sv | 33 +++
 rtl/if_id_queue.sv | 124 ++++++++++++
 tb/tb_if_id_queue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
// Holds the default NOP/HALT encodings, the queue entry layout and a HALT decoder.
// Imported by if_id_queue and if_id_entry_ram.
package if_id_queue_pkg;

    localparam logic [15:0] NOP_WORD_DEF = 16'h0800;
    localparam logic [4:0]  HALT_OP_DEF  = 5'b00000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_next;
    } entry_t;

    // HALT is identified purely by the opcode field [15:11].
    function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] op);
        return instr[15:11] == op;
    endfunction

endpackage

// File: rtl/if_id_entry_ram.sv
// Entry storage for the fetch-to-decode queue: DEPTH x 32-bit register array.
// Ports: clk/rst, write port (wr_en, wr_ptr, wdata), asynchronous read (rd_ptr -> rdata).
// Contents are cleared on reset so no stale entry survives a mid-stream reset.
module if_id_entry_ram
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW  = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_ptr,
    input  entry_t        wdata,
    input  logic [AW-1:0] rd_ptr,
    output entry_t        rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: in-order circular buffer of {instr, pc_next}
// with flush, sticky HALT latching and fetch backpressure through f_ready.
// Ports: fetch side f_*, decode side d_*, flush, halted, count (occupancy).
// Optional macro IF_ID_BYPASS_EN: empty-queue same-cycle pass-through from fetch to decode.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] NOP_WORD = NOP_WORD_DEF,
    parameter logic [4:0]  HALT_OP  = HALT_OP_DEF,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   f_instr,
    input  logic [15:0]   f_pc_next,
    input  logic          f_valid,
    output logic          f_ready,
    output logic [15:0]   d_instr,
    output logic [15:0]   d_pc_next,
    output logic          d_valid,
    input  logic          d_ready,
    input  logic          flush,
    output logic          halted,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          halted_q;
    logic [15:0]   last_pc_q;
    entry_t        head;
    entry_t        wdata;
    logic          head_vld;
    logic          enq;
    logic          bypass;
    logic          wr;
    logic          rd;

    assign head_vld = (count_q != '0);

    // A full queue does not accept even when decode frees a slot this cycle.
    assign f_ready  = (count_q < FULL_CNT) && !halted_q && !flush;
    assign enq      = f_valid && f_ready;

`ifdef IF_ID_BYPASS_EN
    // enq already excludes flush, so a flush suppresses the bypass.
    assign bypass = !head_vld && enq && d_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word is consumed straight from fetch and never stored.
    assign wr    = enq && !bypass;
    assign rd    = head_vld && d_ready;
    assign wdata = '{instr: f_instr, pc_next: f_pc_next};

    if_id_entry_ram #(.DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr),
        .wr_ptr (wr_ptr_q),
        .wdata  (wdata),
        .rd_ptr (rd_ptr_q),
        .rdata  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr, rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (enq && is_halt(f_instr, HALT_OP)) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Remembers whatever was last shown on d_pc_next so it can be held while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pc_q <= '0;
        end else begin
            last_pc_q <= d_pc_next;
        end
    end

    always_comb begin
        d_valid   = head_vld;
        d_instr   = head_vld ? head.instr : NOP_WORD;
        d_pc_next = head_vld ? head.pc_next : last_pc_q;
        if (bypass) begin
            d_valid   = 1'b1;
            d_instr   = f_instr;
            d_pc_next = f_pc_next;
        end
    end

    assign halted = halted_q;
    assign count  = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IF_ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   f_instr;
    logic [15:0]   f_pc_next;
    logic          f_valid;
    logic          f_ready;
    logic [15:0]   d_instr;
    logic [15:0]   d_pc_next;
    logic          d_valid;
    logic          d_ready;
    logic          flush;
    logic          halted;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_instr   (f_instr),
        .f_pc_next (f_pc_next),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .d_instr   (d_instr),
        .d_pc_next (d_pc_next),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .flush     (flush),
        .halted    (halted),
        .count     (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input logic [15:0] fi, input logic [15:0] fp,
                         input logic dr, input logic fl);
        f_valid   = fv;
        f_instr   = fi;
        f_pc_next = fp;
        d_ready   = dr;
        flush     = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        fv;
        logic [15:0] fi;
        logic [15:0] fp;
        logic        dr;
        logic        fl;
        logic        e_rdy;   // f_ready before the edge
        logic        e_dv;    // outputs after the edge
        logic [15:0] e_di;
        logic [15:0] e_dp;
        logic [1:0]  e_cnt;
        logic        e_h;
    } vec_t;

    vec_t tbl[14];

    // Reference model state for the random run.
    logic [31:0] mq[$];
    logic        m_halt;
    logic [15:0] m_last;

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        check("reset_f_ready", 32'(f_ready), 32'd1);
        check("reset_d_valid", 32'(d_valid), 32'd0);
        check("reset_d_instr", 32'(d_instr), 32'h0800);
        check("reset_d_pc", 32'(d_pc_next), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //            fv    fi        fp     dr    fl   rdy   dv    di        dp     cnt   h
        tbl[0]  = '{1'b1, 16'hA001, 16'd2,  1'b0, 1'b0, 1'b1, 1'b1, 16'hA001, 16'd2,  2'd1, 1'b0};
        tbl[1]  = '{1'b1, 16'hA002, 16'd4,  1'b0, 1'b0, 1'b1, 1'b1, 16'hA001, 16'd2,  2'd2, 1'b0};
        tbl[2]  = '{1'b1, 16'hA003, 16'd6,  1'b0, 1'b0, 1'b0, 1'b1, 16'hA001, 16'd2,  2'd2, 1'b0};
        tbl[3]  = '{1'b1, 16'hA003, 16'd6,  1'b1, 1'b0, 1'b0, 1'b1, 16'hA002, 16'd4,  2'd1, 1'b0};
        tbl[4]  = '{1'b0, 16'hA003, 16'd6,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0800, 16'd4,  2'd0, 1'b0};
        tbl[5]  = '{1'b1, 16'hA004, 16'd8,  1'b0, 1'b0, 1'b1, 1'b1, 16'hA004, 16'd8,  2'd1, 1'b0};
        tbl[6]  = '{1'b1, 16'hA005, 16'd10, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA005, 16'd10, 2'd1, 1'b0};
        tbl[7]  = '{1'b1, 16'hA006, 16'd12, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA005, 16'd10, 2'd2, 1'b0};
        tbl[8]  = '{1'b1, 16'hB000, 16'd99, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0800, 16'd10, 2'd0, 1'b0};
        tbl[9]  = '{1'b1, 16'h0000, 16'd14, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'd14, 2'd1, 1'b1};
        tbl[10] = '{1'b1, 16'hC000, 16'd16, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'd14, 2'd1, 1'b1};
        tbl[11] = '{1'b1, 16'hC000, 16'd16, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0800, 16'd14, 2'd0, 1'b1};
        tbl[12] = '{1'b0, 16'h0000, 16'd0,  1'b0, 1'b1, 1'b0, 1'b0, 16'h0800, 16'd14, 2'd0, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 16'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0800, 16'd14, 2'd0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].fv, tbl[i].fi, tbl[i].fp, tbl[i].dr, tbl[i].fl);
            #1;
            check($sformatf("tbl%0d_f_ready", i), 32'(f_ready), 32'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_d_valid", i), 32'(d_valid), 32'(tbl[i].e_dv));
            check($sformatf("tbl%0d_d_instr", i), 32'(d_instr), 32'(tbl[i].e_di));
            check($sformatf("tbl%0d_d_pc", i), 32'(d_pc_next), 32'(tbl[i].e_dp));
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].e_h));
        end

        // Asynchronous reset between edges with two entries queued.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 16'hE000 + 16'(i), 16'(2 * i + 2), 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_d_valid", 32'(d_valid), 32'd0);
        check("async_rst_d_instr", 32'(d_instr), 32'h0800);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_f_ready", 32'(f_ready), 32'd1);
        #1;
        rst = 1'b0;

`ifndef IF_ID_BYPASS_EN
        // Streaming: each word shows up one edge after it is offered.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            drive(1'b1, 16'h1000 + 16'(k), 16'(2 * k), 1'b1, 1'b0);
            #1;
            check($sformatf("stream%0d_f_ready", k), 32'(f_ready), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("stream%0d_d_pc", k), 32'(d_pc_next), 32'(2 * k));
            check($sformatf("stream%0d_count", k), 32'(count), 32'd1);
        end
`else
        // Bypass: empty queue with decode ready passes the word straight through.
        do_reset();
        @(negedge clk);
        drive(1'b1, 16'hD123, 16'h0042, 1'b1, 1'b0);
        #1;
        check("bypass_d_valid", 32'(d_valid), 32'd1);
        check("bypass_d_instr", 32'(d_instr), 32'hD123);
        check("bypass_d_pc", 32'(d_pc_next), 32'h0042);
        check("bypass_count_pre", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        check("bypass_count_post", 32'(count), 32'd0);
        @(negedge clk);
        drive(1'b1, 16'hD124, 16'h0044, 1'b1, 1'b1);
        #1;
        check("bypass_flush_d_valid", 32'(d_valid), 32'd0);
`endif

        // Randomized run against a queue model.
        do_reset();
        mq.delete();
        m_halt = 1'b0;
        m_last = 16'h0;
        for (int c = 0; c < 600; c++) begin
            logic        fv;
            logic        dr;
            logic        fl;
            logic [15:0] fi;
            logic [15:0] fp;
            logic        e_rdy;
            logic        e_enq;
            logic        e_byp;
            logic        e_dv;
            logic [15:0] e_di;
            logic [15:0] e_dp;
            @(negedge clk);
            fv = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 1) != 0);
            fl = ($urandom_range(0, 15) == 0);
            fi = 16'($urandom);
            fp = 16'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                fi[15:11] = 5'b00000;
            end else if (fi[15:11] == 5'b00000) begin
                fi[15] = 1'b1;
            end
            drive(fv, fi, fp, dr, fl);
            #1;
            e_rdy = (mq.size() < DEPTH) && !m_halt && !fl;
            e_enq = fv && e_rdy;
            e_byp = BYP && (mq.size() == 0) && e_enq && dr;
            if (e_byp) begin
                e_dv = 1'b1;
                e_di = fi;
                e_dp = fp;
            end else if (mq.size() > 0) begin
                e_dv = 1'b1;
                e_di = mq[0][31:16];
                e_dp = mq[0][15:0];
            end else begin
                e_dv = 1'b0;
                e_di = 16'h0800;
                e_dp = m_last;
            end
            check("rnd_f_ready", 32'(f_ready), 32'(e_rdy));
            check("rnd_d_valid", 32'(d_valid), 32'(e_dv));
            check("rnd_d_instr", 32'(d_instr), 32'(e_di));
            check("rnd_d_pc", 32'(d_pc_next), 32'(e_dp));
            check("rnd_count", 32'(count), 32'(mq.size()));
            check("rnd_halted", 32'(halted), 32'(m_halt));
            m_last = e_dp;
            if (fl) begin
                mq.delete();
                m_halt = 1'b0;
            end else begin
                if (mq.size() > 0 && dr) begin
                    void'(mq.pop_front());
                end
                if (e_enq && !e_byp) begin
                    mq.push_back({fi, fp});
                end
                if (e_enq && fi[15:11] == 5'b00000) begin
                    m_halt = 1'b1;
                end
            end
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
